// File: rtl/vga_scanout_if.sv
// Pixel-buffer read port between the scanout engine and its frame memory.
// The scanout drives the word address; the memory returns the word one clock later.
interface vga_scanout_if;
    logic [15:0] RADDR_VGA;
    logic [15:0] DATA_OUT_VGA;

    modport master (
        output RADDR_VGA,
        input  DATA_OUT_VGA
    );

    modport slave (
        input  RADDR_VGA,
        output DATA_OUT_VGA
    );
endinterface

// File: rtl/vga_scanout.sv
// VGA raster generator: 25 MHz pixel tick from a 50 MHz clock, double-buffered
// 16-row pixel band reads (two pixels per word) and registered RGB/sync outputs.
module vga_scanout #(
    parameter logic [15:0] BUF1_START = 16'h0000,
    parameter logic [15:0] BUF2_START = 16'h1400,
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33
) (
    input  logic                CLK50MHz,
    input  logic                RST,
    vga_scanout_if.master       mem_bus,
    output logic [10:0]         XCoord,
    output logic [10:0]         YCoord,
    output logic                HSYNC,
    output logic                VSYNC,
    output logic [2:0]          RED,
    output logic [2:0]          GREEN,
    output logic [1:0]          BLUE
);

    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] V_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
    // Each buffer holds a 16-line band; line stride in pixels is fixed at 640.
    localparam logic [15:0] ROW_STRIDE = 16'd640;

    logic        pix_en_q,     pix_en_d;
    logic [10:0] x_q,          x_d;
    logic [10:0] y_q,          y_d;
    logic [15:0] raddr_q,      raddr_d;
    logic [15:0] word_q,       word_d;
    logic        rd_pend_q,    rd_pend_d;
    logic        pend_act_q,   pend_act_d;
    logic        pend_odd_q,   pend_odd_d;
    logic        pend_hs_q,    pend_hs_d;
    logic        pend_vs_q,    pend_vs_d;
    logic [7:0]  rgb_q,        rgb_d;
    logic        hsync_q,      hsync_d;
    logic        vsync_q,      vsync_d;

    logic        in_active;
    logic        in_hsync;
    logic        in_vsync;
    logic [15:0] rd_base;
    logic [15:0] rd_offset;

    assign in_active = (x_q < H_ACT) && (y_q < V_ACT);
    assign in_hsync  = (x_q >= HS_BEG) && (x_q < HS_END);
    assign in_vsync  = (y_q >= VS_BEG) && (y_q < VS_END);
    // The band being shown alternates every 16 lines; the renderer owns the other one.
    assign rd_base   = y_q[4] ? BUF2_START : BUF1_START;
    assign rd_offset = (({12'd0, y_q[3:0]} * ROW_STRIDE) + {5'd0, x_q}) >> 1;

    always_comb begin
        pix_en_d   = ~pix_en_q;
        x_d        = x_q;
        y_d        = y_q;
        raddr_d    = raddr_q;
        word_d     = word_q;
        rd_pend_d  = rd_pend_q;
        pend_act_d = pend_act_q;
        pend_odd_d = pend_odd_q;
        pend_hs_d  = pend_hs_q;
        pend_vs_d  = pend_vs_q;
        rgb_d      = rgb_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;

        if (pix_en_q) begin
            if (x_q == H_LAST) begin
                x_d = 11'd0;
                y_d = (y_q == V_LAST) ? 11'd0 : y_q + 11'd1;
            end else begin
                x_d = x_q + 11'd1;
            end

            if (in_active && !x_q[0]) begin
                raddr_d   = rd_base + rd_offset;
                rd_pend_d = 1'b1;
            end

            // Decisions for this position are staged and shown on the next tick,
            // once the word fetched for it has landed.
            pend_act_d = in_active;
            pend_odd_d = x_q[0];
            pend_hs_d  = in_hsync;
            pend_vs_d  = in_vsync;

            if (pend_act_q) begin
                rgb_d = pend_odd_q ? word_q[7:0] : word_q[15:8];
            end else begin
                rgb_d = 8'd0;
            end
            hsync_d = ~pend_hs_q;
            vsync_d = ~pend_vs_q;
        end else if (rd_pend_q) begin
            word_d    = mem_bus.DATA_OUT_VGA;
            rd_pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK50MHz) begin
        if (RST) begin
            pix_en_q   <= 1'b0;
            x_q        <= 11'd0;
            y_q        <= 11'd0;
            raddr_q    <= BUF1_START;
            word_q     <= 16'd0;
            rd_pend_q  <= 1'b0;
            pend_act_q <= 1'b0;
            pend_odd_q <= 1'b0;
            pend_hs_q  <= 1'b0;
            pend_vs_q  <= 1'b0;
            rgb_q      <= 8'd0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
        end else begin
            pix_en_q   <= pix_en_d;
            x_q        <= x_d;
            y_q        <= y_d;
            raddr_q    <= raddr_d;
            word_q     <= word_d;
            rd_pend_q  <= rd_pend_d;
            pend_act_q <= pend_act_d;
            pend_odd_q <= pend_odd_d;
            pend_hs_q  <= pend_hs_d;
            pend_vs_q  <= pend_vs_d;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    assign mem_bus.RADDR_VGA = raddr_q;
    assign XCoord = x_q;
    assign YCoord = y_q;
    assign HSYNC  = hsync_q;
    assign VSYNC  = vsync_q;
    assign RED    = rgb_q[7:5];
    assign GREEN  = rgb_q[4:2];
    assign BLUE   = rgb_q[1:0];

endmodule
